sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
- Next-generation single-clock FIFO.
- Adds the following over the current sync FIFO:
  - any depth ≥ 2, not only powers of two
  - occupancy count output
  - programmable almost-full and almost-empty flags
  - standard or first-word-fall-through (FWFT) read mode
  - sticky error flags with explicit clear
  - synchronous flush
  - simultaneous read/write when full
- Sits between producer and consumer logic inside one clock domain.

Parameters:
- WIDTH, 8, data word width in bits (≥ 1).
- DEPTH, 16, number of entries (≥ 2; need not be a power of two).
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- AF_TH, DEPTH-2, almost_full asserts when count ≥ AF_TH (1..DEPTH).
- AE_TH, 2, almost_empty asserts when count ≤ AE_TH (0..DEPTH-1).
- PTR_W, $clog2(DEPTH), pointer width (derived).
- CNT_W, $clog2(DEPTH+1), count width (derived).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- res  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wdata  in  WIDTH  write data.
- rd_en  in  1  read request (pop/acknowledge in FWFT mode).
- flush  in  1  synchronous empty-the-FIFO.
- clr_err  in  1  synchronous clear of overflow/underflow.
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata holds a valid word (meaning per mode, below).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_TH.
- almost_empty  out  1  count ≤ AE_TH.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset:
  - Asserting res clears immediately, independent of clk: wr_ptr=0, rd_ptr=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; first edge after release behaves as an empty FIFO.
- Status: full, empty, almost_full, almost_empty are decoded combinationally from the count register only. No combinational path from wr_en/rd_en to status.
- Accept rules:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). Write when full is accepted only if a read is accepted in the same cycle.
  - Read when empty is always rejected, even with a simultaneous write.
- Count update per edge: +1 on wr_acc only, −1 on rd_acc only, unchanged if both or neither.
- Pointers:
  - Each pointer advances by 1 on its accept.
  - Wraps from DEPTH-1 to 0 by explicit compare, not natural overflow.
- Write path: on wr_acc, mem[wr_ptr] ← wdata at the edge.
- Standard read (FWFT=0):
  - On rd_acc, rdata ← mem[rd_ptr] at that edge, and rvalid=1 for exactly the next cycle.
  - Otherwise rvalid=0 and rdata holds its last value.
  - Read latency is 1 cycle.
- FWFT read (FWFT=1):
  - rdata = mem[rd_ptr] combinationally and rvalid = ~empty.
  - rd_en pops the head word; the next word appears after the edge.
  - A word written into an empty FIFO is visible on rdata the cycle after the write edge.
- Error flags:
  - overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & ~rd_acc.
  - Both hold until clr_err.
  - clr_err in the same cycle as a new error: set wins.
  - Rejected operations change no other state.
- Flush:
  - Clears wr_ptr, rd_ptr, count and rvalid at the edge.
  - Has priority over wr_en/rd_en in that cycle; those requests are ignored and not flagged as errors.
  - Does not affect overflow/underflow or rdata (standard mode).

Test Plan:
- Fill and drain (WIDTH=8, DEPTH=5, AF_TH=4, AE_TH=1, FWFT=0):
  - Stimulus: write 0x11..0x55 on 5 consecutive cycles, then read 5 times.
  - Required: count 1,2,3,4,5; almost_full at count=4; full at 5; rdata 0x11..0x55 each one cycle after rd_en with rvalid=1; empty and almost_empty at the end.
- Wrap-around with non-power-of-two depth (DEPTH=5):
  - Stimulus: 12 interleaved write/read pairs with data 0x00..0x0B.
  - Required: output order exactly 0x00..0x0B; pointers pass 4→0 twice; count never exceeds 1.
- Full plus simultaneous write/read:
  - Stimulus: at count=5, assert wr_en=1 (0xAA) and rd_en=1 together.
  - Required: both accepted, count stays 5, overflow=0, 0xAA emerges last.
  - Stimulus: then wr_en alone.
  - Required: overflow=1, count=5.
- Empty errors:
  - Stimulus: rd_en on an empty FIFO with simultaneous wr_en (0x3C).
  - Required: underflow=1, write accepted, count=1.
  - Stimulus: clr_err.
  - Required: underflow=0.
  - Stimulus: clr_err together with another bad read.
  - Required: underflow stays 1.
- FWFT=1:
  - Stimulus: write 0x5A into an empty FIFO.
  - Required: next cycle rvalid=1 and rdata=0x5A with no rd_en.
  - Stimulus: rd_en for one cycle.
  - Required: rvalid=0, empty=1.
- Flush and async reset:
  - Stimulus: at count=3, flush with wr_en=1.
  - Required: count=0, empty=1, no write, no overflow.
  - Stimulus: refill 2 words, then pulse res between clock edges.
  - Required: count=0, empty=1, rvalid=0, all flags 0 before the next edge.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO, any depth, programmable flags, standard or FWFT read, sticky errors, flush.
module sync_fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_acc, rd_acc;
  assign full         = count_q == CNT_W'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CNT_W'(AF_TH);
  assign almost_empty = count_q <= CNT_W'(AE_TH);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign rdata        = FWFT != 0 ? mem[rd_ptr_q] : rdata_q;
  assign rvalid       = FWFT != 0 ? ~empty : rvalid_q;
  always_comb begin
    rd_acc   = rd_en & ~empty;
    wr_acc   = wr_en & (~full | rd_acc);
    wr_ptr_d = flush ? '0 : wr_acc ? (wr_ptr_q == PTR_W'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : rd_acc ? (rd_ptr_q == PTR_W'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = flush ? '0 : (wr_acc & ~rd_acc) ? count_q + 1'b1 :
               (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    rdata_d  = (rd_acc & ~flush) ? mem[rd_ptr_q] : rdata_q;
    rvalid_d = rd_acc & ~flush;
    // a fresh error outranks a clear in the same cycle; flushed requests never flag
    ovf_d    = (wr_en & ~wr_acc & ~flush) | (ovf_q & ~clr_err);
    udf_d    = (rd_en & ~rd_acc & ~flush) | (udf_q & ~clr_err);
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc & ~flush) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: standard and FWFT instances driven in lockstep, checked against a queue model.
module tb_sync_fifo_prog;
  localparam int D = 5;
  logic       clk = 0, res = 1, wr_en = 0, rd_en = 0, flush = 0, clr_err = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata [2];
  logic [2:0] count [2];
  logic       rvalid [2], full [2], empty [2], almost_full [2], almost_empty [2], overflow [2], underflow [2];
  logic [7:0] q [$];
  logic [7:0] m_rd = 0;
  bit         m_rv = 0, m_ovf = 0, m_udf = 0;
  int         errs = 0, checks = 0;
  typedef struct {
    bit w; logic [7:0] d; bit r; int cnt; bit rv; logic [7:0] rd; bit af; bit fu;
  } vec_t;
  vec_t tv [11];
  sync_fifo_prog #(.WIDTH(8), .DEPTH(D), .FWFT(0), .AF_TH(4), .AE_TH(1)) dut0 (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .flush(flush), .clr_err(clr_err),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .full(full[0]), .empty(empty[0]), .almost_full(almost_full[0]),
    .almost_empty(almost_empty[0]), .count(count[0]), .overflow(overflow[0]), .underflow(underflow[0]));
  sync_fifo_prog #(.WIDTH(8), .DEPTH(D), .FWFT(1), .AF_TH(4), .AE_TH(1)) dut1 (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .flush(flush), .clr_err(clr_err),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .full(full[1]), .empty(empty[1]), .almost_full(almost_full[1]),
    .almost_empty(almost_empty[1]), .count(count[1]), .overflow(overflow[1]), .underflow(underflow[1]));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("count", count[i], q.size());
      chk("empty", empty[i], q.size() == 0);
      chk("full", full[i], q.size() == D);
      chk("almost_full", almost_full[i], q.size() >= 4);
      chk("almost_empty", almost_empty[i], q.size() <= 1);
      chk("overflow", overflow[i], m_ovf);
      chk("underflow", underflow[i], m_udf);
    end
    chk("rvalid_std", rvalid[0], m_rv);
    chk("rdata_std", rdata[0], m_rd);
    chk("rvalid_fwft", rvalid[1], q.size() > 0);
    if (q.size() > 0) chk("rdata_fwft", rdata[1], q[0]);
  endtask
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit f = 0, input bit c = 0);
    bit ra, wa;
    wr_en = w; wdata = d; rd_en = r; flush = f; clr_err = c;
    ra = r && q.size() > 0;
    wa = w && (q.size() < D || ra);
    m_ovf = (w && !wa && !f) || (m_ovf && !c);
    m_udf = (r && !ra && !f) || (m_udf && !c);
    if (f) begin
      q.delete();
      m_rv = 0;
    end else begin
      m_rv = ra;
      if (ra) m_rd = q.pop_front();
      if (wa) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  initial begin
    tv[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 8'h44, 1'b0, 4, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 8'h55, 1'b0, 5, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 4, 1'b1, 8'h11, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 8'h22, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h33, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h44, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h55, 1'b0, 1'b0};
    tv[10] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h55, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count[0], 0);
    chk("rst_empty", empty[0], 1);
    chk("rst_ae", almost_empty[0], 1);
    chk("rst_rvalid_fwft", rvalid[1], 0);
    check_all();
    res = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(tv[i].w, tv[i].d, tv[i].r);
      chk("tv_count", count[0], tv[i].cnt);
      chk("tv_rvalid", rvalid[0], tv[i].rv);
      chk("tv_rdata", rdata[0], tv[i].rd);
      chk("tv_af", almost_full[0], tv[i].af);
      chk("tv_full", full[0], tv[i].fu);
    end
    chk("drain_empty", empty[0], 1);
    chk("drain_ae", almost_empty[0], 1);
    for (int i = 0; i < 12; i++) begin
      cycle(1, 8'(i), 0);
      chk("wrap_count", count[0], 1);
      cycle(0, 0, 1);
      chk("wrap_data", rdata[0], i);
    end
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'hB0 + i), 0);
    cycle(1, 8'hAA, 1);
    chk("fullrw_count", count[0], 5);
    chk("fullrw_ovf", overflow[0], 0);
    chk("fullrw_rdata", rdata[0], 8'hB0);
    cycle(1, 8'hCC, 0);
    chk("fullw_ovf", overflow[0], 1);
    chk("fullw_count", count[0], 5);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    chk("full_last", rdata[0], 8'hAA);
    cycle(0, 0, 0, 0, 1);
    chk("ovf_clr", overflow[0], 0);
    cycle(1, 8'h3C, 1);
    chk("emprw_udf", underflow[0], 1);
    chk("emprw_count", count[0], 1);
    cycle(0, 0, 0, 0, 1);
    chk("udf_clr", underflow[0], 0);
    cycle(0, 0, 1);
    chk("emprw_data", rdata[0], 8'h3C);
    cycle(0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    chk("udf_set_wins", underflow[0], 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 8'h5A, 0);
    chk("fwft_rvalid", rvalid[1], 1);
    chk("fwft_rdata", rdata[1], 8'h5A);
    cycle(0, 0, 1);
    chk("fwft_pop_rvalid", rvalid[1], 0);
    chk("fwft_pop_empty", empty[1], 1);
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h61 + i), 0);
    cycle(1, 8'h77, 0, 1);
    chk("flush_count", count[0], 0);
    chk("flush_empty", empty[0], 1);
    chk("flush_ovf", overflow[0], 0);
    chk("flush_udf_kept", underflow[0], 1);
    cycle(1, 8'h81, 0);
    cycle(1, 8'h82, 0);
    chk("refill_head", rdata[1], 8'h81);
    #1 res = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ares_count", count[i], 0);
      chk("ares_empty", empty[i], 1);
      chk("ares_rvalid", rvalid[i], 0);
      chk("ares_full", full[i], 0);
      chk("ares_af", almost_full[i], 0);
      chk("ares_ae", almost_empty[i], 1);
      chk("ares_ovf", overflow[i], 0);
      chk("ares_udf", underflow[i], 0);
    end
    chk("ares_rdata", rdata[0], 0);
    res = 0;
    q.delete();
    m_rd = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
    #1 check_all();
    repeat (500) begin
      cycle(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 9) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
